// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: FSM states,
// operation encodings and the iteration count of the radix-2 datapath.
package mdu_pkg;

  // Datapath width the unit is built for; one iteration per operand bit.
  localparam int unsigned MDU_WIDTH = 16;
  localparam int unsigned ITER      = MDU_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned multiply/divide unit. Operands are captured when an
// operation is accepted; the unit then performs one radix-2 step per cycle
// (shift-add multiply or restoring divide) and presents the result to the
// register bank write port for exactly one write-back cycle.
module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    destIn,
  output logic             busy,
  output logic             rw,
  output logic [WIDTH-1:0] dataIn,
  output logic [AW-1:0]    dest,
  output logic             divZero
);

  import mdu_pkg::*;

  // Counter value during the final RUN iteration.
  localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);

  state_e               state_r;
  logic [4:0]           cnt_r;
  op_e                  op_r;
  logic [AW-1:0]        dest_r;

  // Multiply datapath: multiplicand shifts left, multiplier shifts right,
  // partial products accumulate into a double-width register.
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   prod_r;

  // Divide datapath: dividend bits shift out of quo_r into the partial
  // remainder while quotient bits shift in from the bottom.
  logic [WIDTH-1:0]     divisor_r;
  logic [WIDTH-1:0]     quo_r;
  logic [WIDTH-1:0]     rem_r;

  logic [2*WIDTH-1:0]   prod_nxt_s;
  logic [2*WIDTH-1:0]   mcand_nxt_s;
  logic [WIDTH-1:0]     mplier_nxt_s;
  logic [WIDTH:0]       shift_s;
  logic [WIDTH:0]       diff_s;
  logic [WIDTH-1:0]     rem_nxt_s;
  logic [WIDTH-1:0]     quo_nxt_s;
  logic [WIDTH-1:0]     result_s;

  // One radix-2 step of both algorithms; the result reflects the step in progress.
  always_comb begin
    prod_nxt_s   = prod_r;
    mcand_nxt_s  = {mcand_r[2*WIDTH-2:0], 1'b0};
    mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};
    if (mplier_r[0]) begin
      prod_nxt_s = prod_r + mcand_r;
    end else begin
      prod_nxt_s = prod_r;
    end

    // The remainder is always below the divisor, so the trial difference of
    // the (WIDTH+1)-bit partial remainder borrows exactly when its MSB is set.
    shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s  = shift_s - {1'b0, divisor_r};
    if (diff_s[WIDTH]) begin
      rem_nxt_s = shift_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt_s = diff_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
    end

    if (op_r == OP_DIV) begin
      result_s = quo_nxt_s;
    end else begin
      result_s = prod_nxt_s[WIDTH-1:0];
    end
  end

  // Control FSM with the datapath registers and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 5'd0;
      op_r      <= OP_MUL;
      dest_r    <= {AW{1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      prod_r    <= {(2*WIDTH){1'b0}};
      divisor_r <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      rw        <= 1'b0;
      dataIn    <= {WIDTH{1'b0}};
      dest      <= {AW{1'b0}};
      divZero   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rw      <= 1'b0;
          divZero <= 1'b0;
          dataIn  <= {WIDTH{1'b0}};
          dest    <= {AW{1'b0}};
          if (start) begin
            cnt_r     <= 5'd0;
            op_r      <= op_e'(op);
            dest_r    <= destIn;
            mcand_r   <= {{WIDTH{1'b0}}, a};
            mplier_r  <= b;
            prod_r    <= {(2*WIDTH){1'b0}};
            divisor_r <= b;
            quo_r     <= a;
            rem_r     <= {WIDTH{1'b0}};
            busy      <= 1'b1;
            if ((op == OP_DIV) && (b == {WIDTH{1'b0}})) begin
              // Divide by zero has no iterations: write all-ones straight away.
              state_r <= WB;
              rw      <= 1'b1;
              dataIn  <= {WIDTH{1'b1}};
              dest    <= destIn;
              divZero <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        RUN: begin
          mcand_r  <= mcand_nxt_s;
          mplier_r <= mplier_nxt_s;
          prod_r   <= prod_nxt_s;
          quo_r    <= quo_nxt_s;
          rem_r    <= rem_nxt_s;
          cnt_r    <= cnt_r + 5'd1;
          if (cnt_r == LAST_CNT) begin
            state_r <= WB;
            rw      <= 1'b1;
            dataIn  <= result_s;
            dest    <= dest_r;
            divZero <= 1'b0;
          end else begin
            state_r <= RUN;
          end
        end

        WB: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          rw      <= 1'b0;
          dataIn  <= {WIDTH{1'b0}};
          dest    <= {AW{1'b0}};
          divZero <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          rw      <= 1'b0;
          dataIn  <= {WIDTH{1'b0}};
          dest    <= {AW{1'b0}};
          divZero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases, reset aborts,
// back-to-back operation and randomized operations against an arithmetic model.
module tb_mul_div_unit;

  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  destIn;
  logic        busy;
  logic        rw;
  logic [15:0] dataIn;
  logic [3:0]  dest;
  logic        divZero;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(16), .AW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .destIn  (destIn),
    .busy    (busy),
    .rw      (rw),
    .dataIn  (dataIn),
    .dest    (dest),
    .divZero (divZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the arithmetic definition.
  function automatic logic [15:0] ref_result(input logic o, input logic [15:0] x,
                                             input logic [15:0] y);
    longint unsigned p;
    if (o == 1'b0) begin
      p = 64'(x) * 64'(y);
      return p[15:0];
    end else if (y == 16'd0) begin
      return 16'hFFFF;
    end else begin
      return x / y;
    end
  endfunction

  // Issue one operation from an idle unit (called at a negedge) and check
  // every cycle through the one after write-back. With junk set, the inputs
  // are scrambled (including start) while the unit is busy.
  task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                        input logic [3:0] d, input bit junk);
    int          lat;
    bit          dz;
    logic [15:0] exp_d;
    dz    = (o == 1'b1) && (y == 16'd0);
    lat   = dz ? 1 : int'(ITER) + 1;
    exp_d = ref_result(o, x, y);
    start = 1'b1; op = o; a = x; b = y; destIn = d;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      chk($sformatf("busy op%0d k%0d", o, k), 32'(busy), 32'(k <= lat));
      chk($sformatf("rw op%0d k%0d", o, k), 32'(rw), 32'(k == lat));
      chk($sformatf("divZero op%0d k%0d", o, k), 32'(divZero), 32'((k == lat) && dz));
      chk($sformatf("dataIn %0h/%0h op%0d k%0d", x, y, o, k), 32'(dataIn),
          (k == lat) ? 32'(exp_d) : 32'd0);
      chk($sformatf("dest op%0d k%0d", o, k), 32'(dest), (k == lat) ? 32'(d) : 32'd0);
      if (junk && (k <= lat)) begin
        start  = 1'($urandom_range(0, 1));
        op     = 1'($urandom_range(0, 1));
        a      = 16'($urandom);
        b      = 16'($urandom);
        destIn = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    logic        o;
    logic [15:0] x;
    logic [15:0] y;

    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = 16'd0; b = 16'd0; destIn = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rw", 32'(rw), 32'd0);
    chk("reset divZero", 32'(divZero), 32'd0);
    chk("reset dataIn", 32'(dataIn), 32'd0);
    chk("reset dest", 32'(dest), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);

    // Directed operations.
    run_op(1'b0, 16'd300, 16'd200, 4'd5, 1'b0);
    run_op(1'b0, 16'h1234, 16'h0100, 4'd7, 1'b0);
    run_op(1'b1, 16'd1000, 16'd7, 4'd3, 1'b1);
    run_op(1'b1, 16'd5, 16'd0, 4'd9, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 4'd15, 1'b1);
    run_op(1'b1, 16'hFFFF, 16'd1, 4'd1, 1'b0);
    run_op(1'b1, 16'd3, 16'd10, 4'd2, 1'b0);
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 4'd0, 1'b1);

    // Start held high: second operation accepted right after the first completes.
    start = 1'b1; op = 1'b0; a = 16'd300; b = 16'd200; destIn = 4'd5;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      chk($sformatf("b2b busy k%0d", k), 32'(busy), 32'(!((k == 18) || (k >= 36))));
      chk($sformatf("b2b rw k%0d", k), 32'(rw), 32'((k == 17) || (k == 35)));
      if (k == 17) begin
        chk("b2b first dataIn", 32'(dataIn), 32'h0000EA60);
        chk("b2b first dest", 32'(dest), 32'd5);
      end else if (k == 35) begin
        chk("b2b second dataIn", 32'(dataIn), 32'h0000008E);
        chk("b2b second dest", 32'(dest), 32'd3);
      end else begin
        chk($sformatf("b2b dataIn idle k%0d", k), 32'(dataIn), 32'd0);
      end
      if (k == 18) begin
        op = 1'b1; a = 16'd1000; b = 16'd7; destIn = 4'd3;
      end else if (k == 19) begin
        start = 1'b0;
      end
    end

    // Reset during RUN iteration 8 aborts without a clock edge.
    start = 1'b1; op = 1'b0; a = 16'd300; b = 16'd200; destIn = 4'd5;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("run reset busy", 32'(busy), 32'd0);
    chk("run reset rw", 32'(rw), 32'd0);
    chk("run reset divZero", 32'(divZero), 32'd0);
    @(negedge clk);
    chk("run reset held rw", 32'(rw), 32'd0);
    rst_n = 1'b1;
    run_op(1'b1, 16'd1000, 16'd7, 4'd3, 1'b0);

    // Reset during write-back removes the strobe immediately.
    start = 1'b1; op = 1'b0; a = 16'd300; b = 16'd200; destIn = 4'd5;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset wb rw", 32'(rw), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("wb reset rw", 32'(rw), 32'd0);
    chk("wb reset dataIn", 32'(dataIn), 32'd0);
    chk("wb reset dest", 32'(dest), 32'd0);
    chk("wb reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 16'h1234, 16'h0100, 4'd7, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        y = 16'd0;
      end else if (o && ($urandom_range(0, 1) == 1)) begin
        y = 16'($urandom_range(1, 255));
      end else begin
        y = 16'($urandom);
      end
      run_op(o, x, y, 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
